program_loader: RTL and testbench

Boot-time loader and run controller for the single-cycle core.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit instruction words.
- Writes each word to consecutive word addresses of instruction memory.
- Once the whole image is written, releases the core via the prog_ready/prog_ack handshake to the program counter.
- Sits between the external programming interface and the core top level. It owns the instruction-memory write port and prog_ready.

---
 rtl/program_loader.sv | 181 ++++++++++++++++++
 tb/tb_program_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
// Boot-time loader and run controller for the single-cycle core.
// Receives the program image as a byte stream, packs every four bytes
// little-endian into one instruction word, writes the words to consecutive
// instruction-memory word addresses, then releases the core through the
// prog_ready/prog_ack handshake.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   start, prog_len    load request and image length in words (sampled together)
//   byte_valid/ready   byte-stream handshake, byte_data carries the byte
//   imem_w_en          instruction-memory write strobe
//   imem_wr_addr       word-aligned byte address of the write
//   imem_data_in       packed instruction word
//   prog_ready         core may fetch/execute
//   prog_ack           core acknowledges release
//   busy/done/error    status: loading/releasing, running, sticky fault
module program_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] prog_len,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_w_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_data_in,
    output logic                  prog_ready,
    input  logic                  prog_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RELEASE,
        S_RUN
    } state_t;

    localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_WORDS = ADDR_WIDTH'(MEM_DEPTH / 4);

    state_t                  state;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   len_q;
    logic [ADDR_WIDTH-1:0]   word_cnt;
    logic [1:0]              byte_cnt;
    logic [23:0]             word_buf;
    logic [TMO_W-1:0]        tmo_cnt;

    logic start_ok;
    logic byte_fire;
    logic last_word;
    logic tmo_expired;
    logic accept_start;
    logic reject_start;
    logic tmo_fail;

    assign start_ok    = (prog_len != '0) && (prog_len <= MAX_WORDS);
    // byte_ready is registered from the next state, so it is high exactly in LOAD
    assign byte_fire   = byte_valid && byte_ready;
    assign last_word   = (word_cnt + ADDR_WIDTH'(1)) == len_q;
    assign tmo_expired = tmo_cnt == TMO_W'(ACK_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        accept_start = 1'b0;
        reject_start = 1'b0;
        tmo_fail     = 1'b0;
        case (state)
            S_IDLE, S_RUN: begin
                if (start) begin
                    if (start_ok) begin
                        accept_start = 1'b1;
                        state_d      = S_LOAD;
                    end else begin
                        reject_start = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (byte_fire && (byte_cnt == 2'd3)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = last_word ? S_RELEASE : S_LOAD;
            end
            S_RELEASE: begin
                // an ack sampled in the final timeout cycle still wins
                if (prog_ack) begin
                    state_d = S_RUN;
                end else if (tmo_expired) begin
                    tmo_fail = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_ready   <= 1'b0;
            imem_w_en    <= 1'b0;
            imem_wr_addr <= '0;
            imem_data_in <= '0;
            prog_ready   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            len_q        <= '0;
            word_cnt     <= '0;
            byte_cnt     <= 2'd0;
            word_buf     <= '0;
            tmo_cnt      <= '0;
        end else begin
            byte_ready <= (state_d == S_LOAD);
            imem_w_en  <= (state_d == S_WRITE);
            prog_ready <= (state_d == S_RELEASE) || (state_d == S_RUN);
            busy       <= (state_d == S_LOAD) || (state_d == S_WRITE) ||
                          (state_d == S_RELEASE);
            done       <= (state_d == S_RUN);

            if (accept_start) begin
                error    <= 1'b0;
                len_q    <= prog_len;
                word_cnt <= '0;
                byte_cnt <= 2'd0;
                word_buf <= '0;
            end else if (reject_start || tmo_fail) begin
                error <= 1'b1;
            end

            if (byte_fire) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: word_buf[7:0]   <= byte_data;
                    2'd1: word_buf[15:8]  <= byte_data;
                    2'd2: word_buf[23:16] <= byte_data;
                    default: begin
                        // fourth byte completes the word; present it for the WRITE cycle
                        imem_data_in <= DATA_WIDTH'({byte_data, word_buf});
                        imem_wr_addr <= {word_cnt[ADDR_WIDTH-3:0], 2'b00};
                    end
                endcase
            end

            if (state == S_WRITE) begin
                word_cnt <= word_cnt + ADDR_WIDTH'(1);
            end

            if (state == S_RELEASE) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;

    localparam int AW          = 32;
    localparam int DW          = 32;
    localparam int MEM_DEPTH   = 1024;
    localparam int ACK_TIMEOUT = 16;
    localparam int MAXW        = MEM_DEPTH / 4;

    typedef logic [7:0] byte_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] prog_len;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_w_en;
    logic [AW-1:0] imem_wr_addr;
    logic [DW-1:0] imem_data_in;
    logic          prog_ready;
    logic          prog_ack;
    logic          busy;
    logic          done;
    logic          error;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] wq[$];     // observed writes {addr, data}
    byte_t       img[$];    // current image bytes

    always #5 clk = ~clk;

    program_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (MEM_DEPTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_len    (prog_len),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .imem_w_en   (imem_w_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_data_in(imem_data_in),
        .prog_ready  (prog_ready),
        .prog_ack    (prog_ack),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always @(negedge clk) begin
        if (imem_w_en) wq.push_back({imem_wr_addr, imem_data_in});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_byte_ready"}, byte_ready, 0);
        chk({tag, "_w_en"}, imem_w_en, 0);
        chk({tag, "_addr"}, imem_wr_addr, 0);
        chk({tag, "_data"}, imem_data_in, 0);
        chk({tag, "_prog_ready"}, prog_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    // All tasks are entered and left on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] len);
        start    = 1'b1;
        prog_len = len;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        prog_len = $urandom;    // must have no effect outside the start cycle
    endtask

    task automatic rand_img(input int nw);
        img.delete();
        for (int i = 0; i < 4 * nw; i++) img.push_back(byte_t'($urandom));
    endtask

    // mode 0: valid always high, 1: valid every other cycle, 2: random valid
    task automatic stream(input string tag, input int mode, input int nbytes);
        int idx  = 0;
        int cyc  = 0;
        bit wexp = 1'b0;
        bit v;
        bit acc;
        while (idx < nbytes && cyc < 4000) begin
            if (wexp) begin
                chk({tag, "_wr_latency"}, imem_w_en, 1);
                chk({tag, "_ready_in_write"}, byte_ready, 0);
            end
            wexp = 1'b0;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid = v;
            byte_data  = v ? img[idx] : byte_t'($urandom);
            acc        = v && byte_ready;
            @(posedge clk);
            if (acc) begin
                idx++;
                if (idx % 4 == 0) wexp = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        byte_valid = 1'b0;
        if (wexp) begin
            chk({tag, "_wr_latency"}, imem_w_en, 1);
            chk({tag, "_ready_in_write"}, byte_ready, 0);
        end
        if (idx < nbytes) chk({tag, "_stream_timeout"}, idx, nbytes);
    endtask

    task automatic check_writes(input string tag, input int nwords);
        chk({tag, "_nwr"}, wq.size(), nwords);
        for (int i = 0; i < nwords && i < wq.size(); i++) begin
            int unsigned ed;
            ed = int'(img[4*i]) + int'(img[4*i+1]) * 256 +
                 int'(img[4*i+2]) * 65536 + int'(img[4*i+3]) * 16777216;
            chk({tag, "_addr"}, wq[i][63:32], 4 * i);
            chk({tag, "_data"}, wq[i][31:0], ed);
        end
        wq.delete();
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!prog_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!prog_ready) chk({tag, "_ready_wait"}, prog_ready, 1);
    endtask

    task automatic ack_release(input string tag, input int dly);
        wait_ready(tag);
        for (int i = 0; i < dly; i++) begin
            chk({tag, "_rel_ready"}, {prog_ready, busy, done}, 3'b110);
            @(negedge clk);
        end
        prog_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        prog_ack = 1'b0;
        chk({tag, "_run_done"}, done, 1);
        chk({tag, "_run_busy"}, busy, 0);
        chk({tag, "_run_ready"}, prog_ready, 1);
        chk({tag, "_run_error"}, error, 0);
    endtask

    task automatic expect_timeout(input string tag);
        int n = 0;
        wait_ready(tag);
        while (prog_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_tmo_cycles"}, n, ACK_TIMEOUT);
        chk({tag, "_tmo_error"}, error, 1);
        chk({tag, "_tmo_status"}, {busy, done, byte_ready}, 3'b000);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        prog_len   = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        prog_ack   = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("reset");

        // Two-word image, back-to-back bytes, then ack
        img = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_start(2);
        chk("t1_start", {busy, byte_ready, error}, 3'b110);
        stream("t1", 0, 8);
        @(negedge clk);
        check_writes("t1", 2);
        ack_release("t1", 0);

        // Gappy stream into one word, then let the ack time out
        do_reset();
        img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_start(1);
        stream("t2", 1, 4);
        @(negedge clk);
        chk("t2_word", wq.size() > 0 ? wq[0][31:0] : 64'hX, 32'hDEADBEEF);
        check_writes("t2", 1);
        expect_timeout("t4");

        // Length bounds
        do_start(0);
        chk("t3_len0", {error, busy, byte_ready}, 3'b100);
        do_start(MAXW + 1);
        chk("t3_lenbig", {error, busy, byte_ready}, 3'b100);
        do_start(MAXW);
        chk("t3_lenmax", {error, busy, byte_ready}, 3'b011);
        do_reset();
        chk_reset_vals("t3_rst");
        do_start(1);
        chk("t3_len1", {error, busy, byte_ready}, 3'b011);
        rand_img(1);
        stream("t3", 2, 4);
        @(negedge clk);
        check_writes("t3", 1);
        ack_release("t3", $urandom_range(0, ACK_TIMEOUT - 1));

        // Invalid starts while running keep the core released
        do_start(0);
        chk("run_bad0", {error, prog_ready, done, busy}, 4'b1110);
        do_start(MAXW + 1);
        chk("run_badbig", {error, prog_ready, done, busy}, 4'b1110);

        // Reload from RUN
        do_start(1);
        chk("t6_reload", {prog_ready, done, busy, error}, 4'b0010);
        rand_img(1);
        stream("t6", 0, 4);
        @(negedge clk);
        check_writes("t6", 1);
        ack_release("t6", $urandom_range(0, ACK_TIMEOUT - 1));

        // start is ignored while waiting for the ack
        do_start(2);
        rand_img(2);
        stream("rel", 2, 8);
        @(negedge clk);
        check_writes("rel", 2);
        do_start(1);
        chk("rel_start_ign", {busy, prog_ready, byte_ready, done}, 4'b1100);
        ack_release("rel", $urandom_range(0, ACK_TIMEOUT - 3));

        // Reset in the middle of the second word
        do_start(3);
        rand_img(3);
        stream("t5", 0, 6);
        do_reset();
        chk_reset_vals("t5_rst");
        repeat (3) @(negedge clk);
        check_writes("t5", 1);
        rand_img(2);
        do_start(2);
        stream("t5b", 0, 8);
        @(negedge clk);
        check_writes("t5b", 2);
        ack_release("t5b", $urandom_range(0, ACK_TIMEOUT - 1));

        // Randomized images
        for (int r = 0; r < 6; r++) begin
            int nw;
            nw = $urandom_range(1, 4);
            rand_img(nw);
            do_start(nw);
            chk("rnd_start", {busy, byte_ready, error}, 3'b110);
            stream("rnd", $urandom_range(0, 2), 4 * nw);
            @(negedge clk);
            check_writes("rnd", nw);
            if ($urandom_range(0, 3) == 0) expect_timeout("rnd");
            else ack_release("rnd", $urandom_range(0, ACK_TIMEOUT - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
